// File: rtl/smsl_alert_pkg.sv
// Shared types and defaults for the SMSL alert manager: FSM state encoding,
// default channel map and default actuator/severity masks.
package smsl_alert_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEVE    = 2'd1,
        ST_GRAVE   = 2'd2,
        ST_SILENCE = 2'd3
    } state_e;

    localparam int CH_FRECCARD  = 0;
    localparam int CH_TEMPALTA  = 1;
    localparam int CH_TEMPMEDIA = 2;
    localparam int CH_POSICION  = 3;
    localparam int CH_HUMO      = 4;

    localparam logic [5:0] DEF_GRAVE_MASK = 6'b000011;
    localparam logic [5:0] DEF_LIGHT_MASK = 6'b001011;
    localparam logic [5:0] DEF_VENT_MASK  = 6'b010100;

endpackage

// File: rtl/persist_filter.sv
// Per-channel persistence filter: saturating run-length counter of high samples.
// qual is taken from the next count so a channel qualifies on the PERSIST-th edge.
module persist_filter #(
    parameter int PERSIST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic alert,
    output logic qual
);

    localparam int              CW  = $clog2(PERSIST + 1);
    localparam logic [CW-1:0]   MAX = CW'(PERSIST);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (alert) begin
            cnt_d = (cnt_q == MAX) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign qual = (cnt_d == MAX);

endmodule

// File: rtl/alert_manager.sv
// Clocked alert manager: persistence filtering, ack-able alert latch, severity FSM
// and actuator drive. Define ALERT_ESCALATION_EN to enable LEVE->GRAVE escalation.
module alert_manager
    import smsl_alert_pkg::*;
#(
    parameter int              N_CH           = 6,
    parameter int              PERSIST        = 4,
    parameter logic [N_CH-1:0] GRAVE_MASK     = DEF_GRAVE_MASK,
    parameter int              GRAVE_COUNT    = 3,
    parameter logic [N_CH-1:0] LIGHT_MASK     = DEF_LIGHT_MASK,
    parameter logic [N_CH-1:0] VENT_MASK      = DEF_VENT_MASK,
    parameter int              ESC_CYCLES     = 1024,
    parameter int              SILENCE_CYCLES = 512
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            activacion,
    input  logic [N_CH-1:0] alert_in,
    input  logic            ack,
    output logic            ventilacion,
    output logic            iluminacion,
    output logic            alarm_grave,
    output logic            alarm_leve,
    output logic [N_CH-1:0] latched,
    output logic [1:0]      state
);

    localparam int            SW       = $clog2(SILENCE_CYCLES + 1);
    localparam logic [SW-1:0] SIL_LAST = SW'(SILENCE_CYCLES - 1);

    logic [N_CH-1:0] qual;
    logic [N_CH-1:0] latched_q, latched_d;
    state_e          state_q, state_d;
    logic [SW-1:0]   sil_timer_q, sil_timer_d;
    logic            ventilacion_q, ventilacion_d;
    logic            iluminacion_q, iluminacion_d;
    logic            alarm_grave_q, alarm_grave_d;
    logic            alarm_leve_q, alarm_leve_d;
    logic            esc_flag_q;
    logic            esc_hit;
    logic            new_alert;
    logic            grave_cond;
    logic            any_next;
    int              pop;

    for (genvar i = 0; i < N_CH; i++) begin : g_filter
        persist_filter #(.PERSIST(PERSIST)) u_filter (
            .clk   (clk),
            .rst   (rst),
            .alert (alert_in[i]),
            .qual  (qual[i])
        );
    end

    // ack keeps only the channels that are still qualifying; a fresh set wins.
    always_comb begin
        latched_d = ack ? qual : (latched_q | qual);
        new_alert = |(qual & ~latched_q);
        any_next  = |latched_d;
        pop       = 0;
        for (int i = 0; i < N_CH; i++) begin
            pop = pop + {31'b0, latched_d[i]};
        end
        grave_cond = (|(latched_d & GRAVE_MASK)) || (pop >= GRAVE_COUNT) ||
                     esc_flag_q || esc_hit;
    end

`ifdef ALERT_ESCALATION_EN
    localparam int            EW       = $clog2(ESC_CYCLES + 1);
    localparam logic [EW-1:0] ESC_LAST = EW'(ESC_CYCLES - 1);

    logic [EW-1:0] esc_timer_q, esc_timer_d;
    logic          esc_flag_d;

    always_comb begin
        esc_hit     = (state_q == ST_LEVE) && (esc_timer_q == ESC_LAST);
        esc_timer_d = '0;
        if (state_q == ST_LEVE && state_d == ST_LEVE) begin
            esc_timer_d = (esc_timer_q == ESC_LAST) ? esc_timer_q : esc_timer_q + 1'b1;
        end
        // Sticky so that a silenced escalated alarm comes back as GRAVE.
        esc_flag_d = any_next && (esc_flag_q || esc_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            esc_timer_q <= '0;
            esc_flag_q  <= 1'b0;
        end else begin
            esc_timer_q <= esc_timer_d;
            esc_flag_q  <= esc_flag_d;
        end
    end
`else
    assign esc_hit    = 1'b0;
    assign esc_flag_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_next) state_d = grave_cond ? ST_GRAVE : ST_LEVE;
            end
            ST_LEVE: begin
                if (!any_next)      state_d = ST_IDLE;
                else if (ack)       state_d = ST_SILENCE;
                else if (grave_cond) state_d = ST_GRAVE;
            end
            ST_GRAVE: begin
                if (!any_next) state_d = ST_IDLE;
                else if (ack)  state_d = ST_SILENCE;
            end
            ST_SILENCE: begin
                if (!any_next) begin
                    state_d = ST_IDLE;
                end else if (new_alert || sil_timer_q == SIL_LAST) begin
                    state_d = grave_cond ? ST_GRAVE : ST_LEVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sil_timer_d = '0;
        if (state_q == ST_SILENCE && state_d == ST_SILENCE) begin
            sil_timer_d = (sil_timer_q == SIL_LAST) ? sil_timer_q : sil_timer_q + 1'b1;
        end

        alarm_grave_d = activacion && (state_d == ST_GRAVE);
        alarm_leve_d  = activacion && (state_d == ST_LEVE);
        ventilacion_d = activacion && (|(latched_d & VENT_MASK));
        iluminacion_d = |(latched_d & LIGHT_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latched_q     <= '0;
            state_q       <= ST_IDLE;
            sil_timer_q   <= '0;
            ventilacion_q <= 1'b0;
            iluminacion_q <= 1'b0;
            alarm_grave_q <= 1'b0;
            alarm_leve_q  <= 1'b0;
        end else begin
            latched_q     <= latched_d;
            state_q       <= state_d;
            sil_timer_q   <= sil_timer_d;
            ventilacion_q <= ventilacion_d;
            iluminacion_q <= iluminacion_d;
            alarm_grave_q <= alarm_grave_d;
            alarm_leve_q  <= alarm_leve_d;
        end
    end

    assign latched     = latched_q;
    assign state       = state_q;
    assign ventilacion = ventilacion_q;
    assign iluminacion = iluminacion_q;
    assign alarm_grave = alarm_grave_q;
    assign alarm_leve  = alarm_leve_q;

endmodule
